// File: rtl/packet_flit_sender_pkg.sv
// Shared types for the packet flit sender: flit/ID/count types and sender state.
package packet_flit_sender_pkg;

  localparam int MAX_NUM_OF_FLIT = 8;
  localparam int EXPIRE_TIME     = 100;
  localparam int FLIT_W          = 16;
  localparam int PACKET_ID_W     = 8;
  localparam int FLIT_NUM_W      = 8;
  localparam int FLIT_INDEX_W    = $clog2(MAX_NUM_OF_FLIT);
  localparam int RETRY_W         = 2;

  typedef logic [FLIT_W-1:0]      flit_t;
  typedef logic [PACKET_ID_W-1:0] packet_id_t;
  typedef logic [FLIT_NUM_W-1:0]  flit_num_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } sender_state_t;

  // Transmit-side mirror of the receiver's packet_element_t.
  typedef struct packed {
    packet_id_t                          packet_id;
    logic [FLIT_INDEX_W-1:0]             tail_index;
    flit_t [MAX_NUM_OF_FLIT-1:0]         buffer;
    logic [RETRY_W-1:0]                  retry_cnt;
  } packet_send_element_t;

endpackage

// File: rtl/packet_flit_sender_ack_timer.sv
// Ack timeout counter and retry counter; only built with PACKET_SENDER_RETRANSMIT_EN.
`ifdef PACKET_SENDER_RETRANSMIT_EN
module packet_ack_timer #(
  parameter int TIMEOUT   = 100,
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear_retry,
  input  logic bump_retry,
  output logic expire,
  output logic give_up
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [TW-1:0] timer_q;
  logic [RW-1:0] retry_q;

  // Timer sits at zero outside WAIT_ACK so every entry starts a fresh wait.
  always_ff @(posedge clk) begin
    if (rst || !run) timer_q <= '0;
    else             timer_q <= timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_retry) retry_q <= '0;
    else if (bump_retry)    retry_q <= retry_q + 1'b1;
  end

  assign expire  = run && (timer_q == TW'(TIMEOUT - 1));
  assign give_up = (retry_q == RW'(MAX_RETRY));

endmodule
`endif

// File: rtl/packet_flit_sender.sv
// Latches one packet and streams its flits with ID/index/head/tail tags.
// Optional ack/retransmit support: define PACKET_SENDER_RETRANSMIT_EN.
module packet_flit_sender
  import packet_flit_sender_pkg::*;
#(
  parameter int MAX_FLIT  = MAX_NUM_OF_FLIT,
  parameter int TIMEOUT   = EXPIRE_TIME,
  parameter int MAX_RETRY = 3,
  localparam int IDX_W    = (MAX_FLIT > 1) ? $clog2(MAX_FLIT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid,
  output logic                         pkt_ready,
  input  logic [PACKET_ID_W-1:0]       pkt_id,
  input  logic [FLIT_NUM_W-1:0]        pkt_flit_num,
  input  logic [MAX_FLIT*FLIT_W-1:0]   pkt_flits,
  output logic                         flit_valid,
  input  logic                         flit_ready,
  output logic [FLIT_W-1:0]            flit_out,
  output logic [PACKET_ID_W-1:0]       flit_packet_id,
  output logic [IDX_W-1:0]             flit_index,
  output logic                         flit_is_head,
  output logic                         flit_is_tail,
  output logic                         done,
  output logic                         err
`ifdef PACKET_SENDER_RETRANSMIT_EN
  ,
  input  logic                         ack_valid,
  input  logic [PACKET_ID_W-1:0]       ack_packet_id
`endif
);

  sender_state_t          state, state_n;
  logic [PACKET_ID_W-1:0] id_q;
  logic [IDX_W-1:0]       idx_q, tail_q, tail_in;
  flit_t                  buf_q [MAX_FLIT];
  logic                   done_q, err_q, done_n, err_n;
  logic                   accept, hs, hs_tail, restart;

  assign accept  = pkt_valid & pkt_ready;
  assign hs      = flit_valid & flit_ready;
  assign hs_tail = hs & (idx_q == tail_q);

`ifdef PACKET_SENDER_RETRANSMIT_EN
  logic ack_hit, expire, give_up;

  assign ack_hit = ack_valid && (ack_packet_id == id_q);

  packet_ack_timer #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY)
  ) u_ack_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (state == WAIT_ACK),
    .clear_retry (accept),
    .bump_retry  (restart),
    .expire      (expire),
    .give_up     (give_up)
  );
`else
  localparam int unused_cfg = TIMEOUT + MAX_RETRY;
`endif

  // Oversized packets are clamped; N == 0 never reaches this path.
  always_comb begin
    if (pkt_flit_num > FLIT_NUM_W'(MAX_FLIT)) tail_in = IDX_W'(MAX_FLIT - 1);
    else                                      tail_in = IDX_W'(pkt_flit_num - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pkt_ready  = 1'b0;
    flit_valid = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          if (pkt_flit_num == '0) err_n   = 1'b1;
          else                    state_n = SEND;
        end
      end
      SEND: begin
        flit_valid = 1'b1;
        if (hs_tail) begin
`ifdef PACKET_SENDER_RETRANSMIT_EN
          state_n = WAIT_ACK;
`else
          state_n = IDLE;
          done_n  = 1'b1;
`endif
        end
      end
`ifdef PACKET_SENDER_RETRANSMIT_EN
      WAIT_ACK: begin
        // A matching ack on the expiry cycle still counts as success.
        if (ack_hit) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (expire) begin
          if (give_up) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = SEND;
            restart = 1'b1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q   <= '0;
      idx_q  <= '0;
      tail_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_n;
      err_q  <= err_n;
      if (accept) begin
        id_q   <= pkt_id;
        tail_q <= tail_in;
        idx_q  <= '0;
      end else if (restart) begin
        idx_q  <= '0;
      end else if (hs && !hs_tail) begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < MAX_FLIT; k++) buf_q[k] <= pkt_flits[k*FLIT_W +: FLIT_W];
    end
  end

  assign flit_out       = (state == SEND) ? buf_q[idx_q] : '0;
  assign flit_packet_id = id_q;
  assign flit_index     = idx_q;
  assign flit_is_head   = (idx_q == '0);
  assign flit_is_tail   = (idx_q == tail_q);
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/packet_flit_sender.md
Name: packet_flit_sender

Overview:
- Transmit-side counterpart of the flit reassembly buffer.
- Latches one whole packet, up to MAX_NUM_OF_FLIT flits, from the packet generator.
- Emits the flits one per handshake in index order 0..N-1, tagged with packet ID, index, head flag and tail flag.
- Sits between the packet builder and the link/router output port. Downstream, the receiver's packet_element_t buffer rebuilds the packet.

Parameters:
- MAX_FLIT, default packet_types::MAX_NUM_OF_FLIT (8): capacity of the flit buffer.
- TIMEOUT, default packet_types::EXPIRE_TIME (100): ack wait, in cycles. Used only with the optional feature.
- MAX_RETRY, default 3: number of retransmissions before the packet is dropped. Used only with the optional feature.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pkt_valid  in  1  packet offer.
- pkt_ready  out  1  sender can accept a packet.
- pkt_id  in  types::packet_id_t  ID of the offered packet.
- pkt_flit_num  in  types::flit_num_t  flit count N.
- pkt_flits  in  types::flit_t[MAX_FLIT]  flit payloads, index 0 = head.
- flit_valid  out  1  flit_out is valid.
- flit_ready  in  1  downstream accepts the flit.
- flit_out  out  types::flit_t  current flit.
- flit_packet_id  out  types::packet_id_t  ID of the packet in flight.
- flit_index  out  $clog2(MAX_FLIT)  index of the current flit.
- flit_is_head  out  1  flit_index == 0.
- flit_is_tail  out  1  flit_index == tail_index.
- done  out  1  one-cycle pulse: packet completed.
- err  out  1  one-cycle pulse: packet rejected or dropped.

Behaviour:
- Reset values:
  - State IDLE.
  - pkt_ready = 1.
  - flit_valid = 0; done = 0; err = 0.
  - flit_out, flit_packet_id, flit_index = 0.
  - Buffer contents are don't-care.
- Reset mid-packet aborts the packet silently: no done, no err.
- IDLE:
  - pkt_ready = 1.
  - Transfer on pkt_valid & pkt_ready: latch pkt_id, the buffer, and tail_index = min(N, MAX_FLIT) - 1. Then go to SEND with index = 0.
  - N > MAX_FLIT is clamped to MAX_FLIT.
  - N == 0: packet is accepted and discarded. err pulses the next cycle. State stays IDLE.
- SEND:
  - pkt_ready = 0 and flit_valid = 1.
  - The first flit is valid the cycle after the packet transfer, i.e. latency 1.
  - flit_out = buffer[index].
  - While flit_valid & !flit_ready, all flit_* outputs are held stable.
  - On a handshake of a non-tail flit: index increments by 1.
  - On a handshake of the tail flit: flit_valid drops the next cycle, and
    - without the feature: done pulses and the state returns to IDLE;
    - with the feature: the state goes to WAIT_ACK.
  - Back-to-back packets: pkt_ready rises the cycle after the tail handshake. Minimum gap between packets is 1 cycle.
- Single-flit packet (N = 1): flit_is_head and flit_is_tail are both 1.
- flit_index never exceeds tail_index; no wrap-around.
- flit_valid never depends combinationally on flit_ready.

Optional Feature:
- Macro: PACKET_SENDER_RETRANSMIT_EN.
- With the macro defined:
  - Extra ports: ack_valid in 1, and ack_packet_id in types::packet_id_t.
  - WAIT_ACK state:
    - Timer width $clog2(TIMEOUT). It resets to 0 on entry and increments every cycle.
    - ack_valid with ack_packet_id == latched ID: done pulses and the state goes to IDLE.
    - An ack with a mismatched ID is ignored.
    - If the matching ack arrives in the same cycle the timer reaches TIMEOUT-1, the ack wins.
    - Timer reaches TIMEOUT-1 with no ack:
      - retry_cnt < MAX_RETRY: retry_cnt increments, then SEND resumes from index 0.
      - retry_cnt == MAX_RETRY: err pulses, the packet is dropped, and the state goes to IDLE.
    - Any ack during SEND or IDLE is ignored.
  - retry_cnt clears on every packet accept.
- Without the macro: no ack ports, no timer, no WAIT_ACK state. done pulses on the tail handshake.

Decomposition:
- Add to packet_types:
  - enum sender_state_t {IDLE, SEND, WAIT_ACK}.
  - FLIT_INDEX_W = $clog2(MAX_NUM_OF_FLIT).
  - struct packet_send_element_t {packet_id, tail_index, buffer[MAX_NUM_OF_FLIT], retry_cnt}, mirroring packet_element_t.
- Existing flit, ID and count types are reused from types.
- Natural sub-module: packet_ack_timer (timeout counter plus retry counter with expire/give-up outputs), instantiated only under the macro.

Test Plan:
- Reset, then idle: pkt_ready = 1, flit_valid = 0. Offer ID = 5, N = 3, flits A, B, C with flit_ready = 1 -> flits A, B, C on 3 consecutive cycles starting 1 cycle after accept. Flags head@0 and tail@2. done pulses 1 cycle after C. pkt_ready returns high.
- Same packet with flit_ready toggling 0, 0, 1 per flit -> every flit is held stable 2 cycles, no flit is skipped or duplicated, and index order is 0, 1, 2.
- N = 1 -> one flit with head = tail = 1. N = 0 -> no flit_valid and one err pulse. N = 12 -> exactly 8 flits, indices 0..7.
- Assert rst during index 1 of a 4-flit packet -> next cycle flit_valid = 0 and pkt_ready = 1. No done or err pulse.
- RETRANSMIT_EN, ID = 9: ack with ID = 4 at cycle 10 is ignored. No ack for 100 cycles -> the packet resends from index 0. Ack with ID = 9 after the resend -> done pulses and the state is IDLE.
- RETRANSMIT_EN, MAX_RETRY = 3, no acks -> 4 full transmissions, then err pulses once and pkt_ready = 1. An ack arriving exactly at timer = 99 -> done pulses and no retransmission.
